// File: rtl/qspi_flash_arbiter.sv
// Quad-I/O fast-read (EBh) sequencer that shares one SPI flash between two
// 32-bit read ports with round-robin arbitration. SCLK runs at clk/2, mode 0.
module qspi_flash_arbiter #(
    parameter int ADDR_WIDTH   = 24,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic [31:0]           req0_rdata,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic [31:0]           req1_rdata,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic [3:0]            spi_io_out,
    output logic [3:0]            spi_io_oe,
    input  logic [3:0]            spi_io_in
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_MODE  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_DATA  = 3'd5,
        ST_DONE  = 3'd6,
        ST_DESEL = 3'd7
    } state_t;

    localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
    localparam logic [3:0] DUMMY_LAST    = 4'(DUMMY_CYCLES - 1);

    state_t      state_r, nxt_state_s;
    logic [3:0]  cnt_r, nxt_cnt_s;
    logic        sclk_r, nxt_sclk_s;
    logic        cs_n_r, nxt_cs_n_s;
    logic [3:0]  io_out_r, nxt_io_out_s;
    logic [3:0]  io_oe_r, nxt_io_oe_s;
    logic [23:0] addr_r, nxt_addr_s;
    logic [27:0] shift_r, nxt_shift_s;
    logic        grant_r, nxt_grant_s;
    logic        last_grant_r, nxt_last_grant_s;
    logic        ready0_r, nxt_ready0_s;
    logic        ready1_r, nxt_ready1_s;
    logic [31:0] rdata0_r, nxt_rdata0_s;
    logic [31:0] rdata1_r, nxt_rdata1_s;
    logic        win_s;
    logic [23:0] req_addr_s;
    logic [31:0] word_be_s;
    logic [31:0] word_le_s;

    function automatic logic [3:0] phase_last(input state_t st);
        logic [3:0] last;
        case (st)
            ST_CMD:   last = 4'd7;
            ST_ADDR:  last = 4'd5;
            ST_MODE:  last = 4'd1;
            ST_DUMMY: last = DUMMY_LAST;
            ST_DATA:  last = 4'd7;
            default:  last = 4'd0;
        endcase
        return last;
    endfunction

    function automatic state_t phase_next(input state_t st);
        state_t nxt;
        case (st)
            ST_CMD:   nxt = ST_ADDR;
            ST_ADDR:  nxt = ST_MODE;
            ST_MODE:  nxt = ST_DUMMY;
            ST_DUMMY: nxt = ST_DATA;
            ST_DATA:  nxt = ST_DONE;
            default:  nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [3:0] drive_nibble(input state_t st, input logic [3:0] cnt,
                                                input logic [23:0] addr);
        logic [3:0] nib;
        case (st)
            ST_CMD: nib = {3'b000, CMD_QUAD_READ[3'd7 - cnt[2:0]]};
            ST_ADDR: begin
                case (cnt[2:0])
                    3'd0:    nib = addr[23:20];
                    3'd1:    nib = addr[19:16];
                    3'd2:    nib = addr[15:12];
                    3'd3:    nib = addr[11:8];
                    3'd4:    nib = addr[7:4];
                    default: nib = addr[3:0];
                endcase
            end
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    function automatic logic [3:0] oe_for(input state_t st);
        logic [3:0] oe;
        case (st)
            ST_CMD:  oe = 4'b0001;
            ST_ADDR: oe = 4'b1111;
            ST_MODE: oe = 4'b1111;
            default: oe = 4'b0000;
        endcase
        return oe;
    endfunction

    // Nibbles arrive as byte0-hi, byte0-lo, ...; rdata is little-endian by byte.
    assign word_be_s = {shift_r, spi_io_in};
    assign word_le_s = {word_be_s[7:0], word_be_s[15:8], word_be_s[23:16], word_be_s[31:24]};

    // Next-state, arbitration and SPI pin values
    always_comb begin
        nxt_state_s      = state_r;
        nxt_cnt_s        = cnt_r;
        nxt_sclk_s       = sclk_r;
        nxt_cs_n_s       = cs_n_r;
        nxt_io_out_s     = io_out_r;
        nxt_io_oe_s      = io_oe_r;
        nxt_addr_s       = addr_r;
        nxt_shift_s      = shift_r;
        nxt_grant_s      = grant_r;
        nxt_last_grant_s = last_grant_r;
        nxt_ready0_s     = 1'b0;
        nxt_ready1_s     = 1'b0;
        nxt_rdata0_s     = rdata0_r;
        nxt_rdata1_s     = rdata1_r;
        win_s            = 1'b0;
        req_addr_s       = 24'h000000;

        case (state_r)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        win_s = ~last_grant_r;
                    end else begin
                        win_s = req1_valid;
                    end
                    req_addr_s       = win_s ? 24'(req1_addr) : 24'(req0_addr);
                    nxt_addr_s       = {req_addr_s[23:2], 2'b00};
                    nxt_grant_s      = win_s;
                    nxt_last_grant_s = win_s;
                    nxt_state_s      = ST_CMD;
                    nxt_cnt_s        = 4'd0;
                    nxt_sclk_s       = 1'b0;
                    nxt_cs_n_s       = 1'b0;
                    nxt_io_out_s     = drive_nibble(ST_CMD, 4'd0, addr_r);
                    nxt_io_oe_s      = oe_for(ST_CMD);
                end else begin
                    nxt_cs_n_s = 1'b1;
                    nxt_sclk_s = 1'b0;
                end
            end
            ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA: begin
                if (!sclk_r) begin
                    nxt_sclk_s = 1'b1;
                end else begin
                    // Edge ending the high half: sample, then advance the bit period
                    nxt_sclk_s = 1'b0;
                    if (state_r == ST_DATA) begin
                        nxt_shift_s = {shift_r[23:0], spi_io_in};
                    end else begin
                        nxt_shift_s = shift_r;
                    end
                    if (cnt_r == phase_last(state_r)) begin
                        nxt_state_s = phase_next(state_r);
                        nxt_cnt_s   = 4'd0;
                    end else begin
                        nxt_cnt_s = cnt_r + 4'd1;
                    end
                    if (nxt_state_s == ST_DONE) begin
                        nxt_cs_n_s   = 1'b1;
                        nxt_io_out_s = 4'h0;
                        nxt_io_oe_s  = 4'b0000;
                        if (grant_r) begin
                            nxt_ready1_s = 1'b1;
                            nxt_rdata1_s = word_le_s;
                        end else begin
                            nxt_ready0_s = 1'b1;
                            nxt_rdata0_s = word_le_s;
                        end
                    end else begin
                        nxt_io_out_s = drive_nibble(nxt_state_s, nxt_cnt_s, addr_r);
                        nxt_io_oe_s  = oe_for(nxt_state_s);
                    end
                end
            end
            ST_DONE: begin
                nxt_state_s = ST_DESEL;
            end
            ST_DESEL: begin
                nxt_state_s = ST_IDLE;
            end
            default: begin
                nxt_state_s  = ST_IDLE;
                nxt_cs_n_s   = 1'b1;
                nxt_sclk_s   = 1'b0;
                nxt_io_out_s = 4'h0;
                nxt_io_oe_s  = 4'b0000;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            sclk_r       <= 1'b0;
            cs_n_r       <= 1'b1;
            io_out_r     <= 4'h0;
            io_oe_r      <= 4'b0000;
            addr_r       <= 24'h000000;
            shift_r      <= 28'h0000000;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            ready0_r     <= 1'b0;
            ready1_r     <= 1'b0;
            rdata0_r     <= 32'h00000000;
            rdata1_r     <= 32'h00000000;
        end else begin
            state_r      <= nxt_state_s;
            cnt_r        <= nxt_cnt_s;
            sclk_r       <= nxt_sclk_s;
            cs_n_r       <= nxt_cs_n_s;
            io_out_r     <= nxt_io_out_s;
            io_oe_r      <= nxt_io_oe_s;
            addr_r       <= nxt_addr_s;
            shift_r      <= nxt_shift_s;
            grant_r      <= nxt_grant_s;
            last_grant_r <= nxt_last_grant_s;
            ready0_r     <= nxt_ready0_s;
            ready1_r     <= nxt_ready1_s;
            rdata0_r     <= nxt_rdata0_s;
            rdata1_r     <= nxt_rdata1_s;
        end
    end

    assign spi_sclk   = sclk_r;
    assign spi_cs_n   = cs_n_r;
    assign spi_io_out = io_out_r;
    assign spi_io_oe  = io_oe_r;
    assign req0_ready = ready0_r;
    assign req1_ready = ready1_r;
    assign req0_rdata = rdata0_r;
    assign req1_rdata = rdata1_r;

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// Directed bench for qspi_flash_arbiter: checks every SPI cycle of each read,
// arbitration order, handshake corner cases and mid-transfer reset.
module tb_qspi_flash_arbiter;

    localparam int DUMMY = 4;
    localparam int NPER  = 24 + DUMMY;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [23:0] req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_rdata, req1_rdata;
    logic        spi_sclk, spi_cs_n;
    logic [3:0]  spi_io_out, spi_io_oe, spi_io_in;

    logic        v8_0, v8_1, rdy8_0, rdy8_1, sclk8, cs_n8;
    logic [23:0] a8_0, a8_1;
    logic [31:0] rd8_0, rd8_1;
    logic [3:0]  io_out8, io_oe8, io_in8;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata [2];
    int          ready_cnt [2];
    int          lat8;

    qspi_flash_arbiter #(.ADDR_WIDTH(24), .DUMMY_CYCLES(DUMMY)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe),
        .spi_io_in(spi_io_in)
    );

    qspi_flash_arbiter #(.ADDR_WIDTH(24), .DUMMY_CYCLES(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v8_0), .req0_addr(a8_0), .req0_ready(rdy8_0), .req0_rdata(rd8_0),
        .req1_valid(v8_1), .req1_addr(a8_1), .req1_ready(rdy8_1), .req1_rdata(rd8_1),
        .spi_sclk(sclk8), .spi_cs_n(cs_n8), .spi_io_out(io_out8), .spi_io_oe(io_oe8),
        .spi_io_in(io_in8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        spi_io_in = 4'h0;
        @(negedge clk);
        chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("rst_oe", {28'd0, spi_io_oe}, 32'd0);
        chk("rst_io", {28'd0, spi_io_out}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_rdata0", req0_rdata, 32'd0);
        chk("rst_rdata1", req1_rdata, 32'd0);
        rst_n = 1'b1;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        ready_cnt[0] = 0;
        ready_cnt[1] = 0;
    endtask

    // CS# stays high, no ready, through DESEL and the following IDLE cycle
    task automatic gap();
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            chk("gap_cs_n", {31'd0, spi_cs_n}, 32'd1);
            chk("gap_sclk", {31'd0, spi_sclk}, 32'd0);
            chk("gap_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
    endtask

    // Caller leaves the DUT idle with a valid raised so the next edge accepts.
    task automatic txn(input int port, input logic [23:0] exp_addr, input logic [31:0] word,
                       input int abort_at, input int drop_at);
        logic [7:0] cmd;
        logic [3:0] exp_oe;
        logic [3:0] exp_io;
        int p;
        int j;
        cmd = 8'hEB;
        for (int k = 1; k <= 2 * NPER; k++) begin
            @(negedge clk);
            p = (k - 1) / 2;
            chk("cs_n_low", {31'd0, spi_cs_n}, 32'd0);
            chk("sclk_phase", {31'd0, spi_sclk}, {31'd0, (k % 2 == 0)});
            chk("ready_early", {30'd0, req1_ready, req0_ready}, 32'd0);
            if (p < 8) begin
                exp_oe = 4'b0001;
                exp_io = {3'b000, cmd[7 - p]};
            end else if (p < 14) begin
                exp_oe = 4'b1111;
                exp_io = exp_addr[(13 - p) * 4 +: 4];
            end else if (p < 16) begin
                exp_oe = 4'b1111;
                exp_io = 4'h0;
            end else begin
                exp_oe = 4'b0000;
                exp_io = 4'h0;
            end
            chk("io_oe", {28'd0, spi_io_oe}, {28'd0, exp_oe});
            if (p < 16) chk("io_out", {28'd0, spi_io_out}, {28'd0, exp_io});
            if (k % 2 == 1) begin
                if (p >= 16 + DUMMY) begin
                    j = p - 16 - DUMMY;
                    spi_io_in = (j % 2 == 0) ? word[8 * (j / 2) + 4 +: 4] : word[8 * (j / 2) +: 4];
                end else begin
                    spi_io_in = 4'h0;
                end
            end
            if (k == drop_at) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                req0_addr = 24'hFFFFFF;
                req1_addr = 24'hFFFFFF;
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
                chk("abort_oe", {28'd0, spi_io_oe}, 32'd0);
                chk("abort_sclk", {31'd0, spi_sclk}, 32'd0);
                chk("abort_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
                rst_n = 1'b1;
                exp_rdata[0] = 32'd0;
                exp_rdata[1] = 32'd0;
                return;
            end
        end
        @(negedge clk);
        chk("ready_pulse", {30'd0, req1_ready, req0_ready}, (port == 1) ? 32'd2 : 32'd1);
        chk("rdata_port", (port == 1) ? req1_rdata : req0_rdata, word);
        chk("rdata_other", (port == 1) ? req0_rdata : req1_rdata, exp_rdata[1 - port]);
        chk("done_cs_n", {31'd0, spi_cs_n}, 32'd1);
        chk("done_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("done_oe", {28'd0, spi_io_oe}, 32'd0);
        exp_rdata[port] = word;
        ready_cnt[0] += int'(req0_ready);
        ready_cnt[1] += int'(req1_ready);
        spi_io_in = 4'h0;
    endtask

    initial begin
        req0_addr = 24'd0;
        req1_addr = 24'd0;
        v8_0 = 1'b0;
        v8_1 = 1'b0;
        a8_0 = 24'd0;
        a8_1 = 24'd0;
        io_in8 = 4'h0;
        lat8 = 0;
        do_reset();

        // Single read of the word at 0x100
        req0_valid = 1'b1;
        req0_addr = 24'h000100;
        txn(0, 24'h000100, 32'h00000013, 0, 0);
        req0_valid = 1'b0;
        gap();

        // Unaligned address is sent word-aligned
        req1_valid = 1'b1;
        req1_addr = 24'h000103;
        txn(1, 24'h000100, 32'h00000013, 0, 0);
        req1_valid = 1'b0;
        gap();

        // Contention after reset: 0, then 1, then a third tie to 0
        do_reset();
        req0_valid = 1'b1;
        req0_addr = 24'h000204;
        req1_valid = 1'b1;
        req1_addr = 24'h00ABC8;
        txn(0, 24'h000204, 32'hDEADBEEF, 0, 0);
        req0_valid = 1'b0;
        gap();
        txn(1, 24'h00ABC8, 32'h12345678, 0, 0);
        req0_valid = 1'b1;
        req0_addr = 24'h000300;
        gap();
        txn(0, 24'h000300, 32'hCAFEF00D, 0, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        gap();

        // Both held continuously: grants alternate and stay balanced
        do_reset();
        req0_valid = 1'b1;
        req0_addr = 24'h000400;
        req1_valid = 1'b1;
        req1_addr = 24'h000801;
        for (int i = 0; i < 4; i++) begin
            txn(i % 2, (i % 2 == 1) ? 24'h000800 : 24'h000400,
                (i % 2 == 1) ? 32'h55667788 : 32'h11223344, 0, 0);
            chk("fairness", {31'd0, (ready_cnt[0] - ready_cnt[1] <= 1) && (ready_cnt[1] - ready_cnt[0] <= 1)}, 32'd1);
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            gap();
        end
        chk("ready_cnt0", ready_cnt[0], 32'd2);
        chk("ready_cnt1", ready_cnt[1], 32'd2);

        // Valid and address dropped after acceptance: read still completes
        req1_valid = 1'b1;
        req1_addr = 24'h000010;
        txn(1, 24'h000010, 32'h0BADC0DE, 0, 5);
        gap();

        // Reset pulse in the DATA phase, then a normal read
        req0_valid = 1'b1;
        req0_addr = 24'h000100;
        txn(0, 24'h000100, 32'h00000013, 2 * (16 + DUMMY) + 5, 0);
        txn(0, 24'h000100, 32'h00000013, 0, 0);
        req0_valid = 1'b0;
        gap();

        // Eight dummy cycles: ready lands in cycle 65
        v8_0 = 1'b1;
        a8_0 = 24'h000040;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (lat8 == 0 && rdy8_0) begin
                lat8 = k;
                v8_0 = 1'b0;
            end
        end
        chk("dummy8_latency", lat8, 32'd65);
        chk("dummy8_rdata", rd8_0, 32'd0);
        chk("dummy8_idle", {rd8_1[23:0], rdy8_1, sclk8, cs_n8, io_out8, io_oe8}, 32'h00000100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_flash_arbiter.md
Name: qspi_flash_arbiter

Overview:
- Sequences quad-I/O fast reads (command EBh) from the external SPI flash on the uio pins.
- Shares that single flash between two 32-bit read requesters: port 0 is CPU instruction fetch, port 1 is the CPU data/load path.
- Sits between the SoC bus fabric and the uio pad mapping:
  - uio_out[7] is SCLK and uio_out[6] is CS#.
  - uio[4:1] carry IO3..IO0.
- Read-only. Writes and erase stay with the software bit-bang path, outside this block.

Parameters:
- ADDR_WIDTH, 24, flash byte-address width.
- DUMMY_CYCLES, 4, SCLK cycles between mode byte and data. Legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  port 0 read request
- req0_addr  in  ADDR_WIDTH  port 0 byte address
- req0_ready  out  1  port 0 completion pulse
- req0_rdata  out  32  port 0 read data
- req1_valid  in  1  port 1 read request
- req1_addr  in  ADDR_WIDTH  port 1 byte address
- req1_ready  out  1  port 1 completion pulse
- req1_rdata  out  32  port 1 read data
- spi_sclk  out  1  flash clock
- spi_cs_n  out  1  flash chip select, active low
- spi_io_out  out  4  IO3..IO0 output values
- spi_io_oe  out  4  IO3..IO0 output enables, 1 = drive
- spi_io_in  in  4  IO3..IO0 sampled pins

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_io_oe=0, spi_io_out=0, req*_ready=0, req*_rdata=0, last_grant=1, state IDLE.
  - Reset asserted mid-transaction aborts at the next edge: CS# rises and no ready pulse is issued.
- SCLK timing (mode 0):
  - SCLK = clk/2, idle low.
  - Each SCLK period is one low cycle followed by one high cycle.
  - Outputs change only while entering the low half.
  - spi_io_in is sampled at the clk edge that ends the high half.
- States: IDLE -> CMD -> ADDR -> MODE -> DUMMY -> DATA -> DONE -> DESEL -> IDLE.
- IDLE: at the first edge where any valid is high, do all of the following at that edge:
  - Choose the granted port.
  - Latch its address, forcing addr[1:0]=0.
  - Go to CMD.
  - spi_cs_n falls in the following cycle.
- Arbitration (round robin):
  - Only one port valid: that port wins.
  - Both valid: the port != last_grant wins.
  - last_grant updates at acceptance.
  - After reset, port 0 wins the first tie.
- CMD: 8 SCLK periods, 0xEB MSB first on IO0. spi_io_oe=0001, unused outputs 0.
- ADDR: 6 SCLK periods, 24-bit address MSB nibble first. oe=1111.
  - If ADDR_WIDTH<24, the upper bits are zero-padded.
- MODE: 2 SCLK periods, nibbles 0x0,0x0 (continuous-read mode off). oe=1111.
- DUMMY: DUMMY_CYCLES SCLK periods. oe=0000.
- DATA: 8 SCLK periods, oe=0000.
  - Each byte arrives high nibble first.
  - Assembled little-endian: first byte -> rdata[7:0], fourth byte -> rdata[31:24].
- DONE: one cycle. Granted port's ready=1 and its rdata updated; spi_cs_n=1, spi_sclk=0.
  - The other port's rdata holds its previous value.
- DESEL: spi_cs_n held high for 2 further cycles. No acceptance until DESEL ends.
- Latency: with N = 24 + DUMMY_CYCLES SCLK periods, ready is high in cycle 2N+1 after the acceptance edge. Default N=28 gives cycle 57.
- Handshake:
  - Requester holds valid and addr until it sees ready.
  - ready is a single-cycle pulse.
  - A requester may drop valid in the ready cycle. If valid is still high in the cycle after DESEL, that is a new request.
  - If valid drops before ready, the transaction still completes and pulses ready.
  - addr changes after acceptance are ignored.
- Minimum CS# high time between back-to-back transactions is 3 clk cycles (DONE + DESEL).

Test Plan:
- Single read: flash word at 0x000100 = bytes 13 00 00 00, req0 valid addr 0x000100.
  - IO0 carries 0xEB, then nibbles 0,0,0,1,0,0, then mode 0,0.
  - req0_ready pulses at cycle 57 with rdata 0x00000013.
- Alignment: req1 addr 0x000103.
  - Address phase sends 0x000100.
  - req1_rdata equals the word at 0x100.
- Contention: req0 and req1 valid in the same cycle after reset.
  - Port 0 served first, then port 1.
  - spi_cs_n high for exactly 3 cycles between the two transactions.
  - A third tie then goes to port 0.
- Starvation: req0 held valid continuously while req1 is asserted.
  - Grants alternate 0,1,0,1.
  - Each port's ready count differs by at most 1.
- Reset mid-DATA: rst_n low for 1 cycle during the DATA phase.
  - Next cycle: spi_cs_n=1, oe=0, sclk=0, no ready pulse.
  - A subsequent request completes normally.
- Protocol checker over all runs:
  - sclk toggles only while cs_n=0; oe=0001 in CMD; oe=0000 in DUMMY and DATA.
  - DUMMY_CYCLES=8 build gives ready at cycle 65.
